// File: rtl/spi_request_arbiter_pkg.sv
// Shared definitions for the SPI request arbiter: FSM state encoding,
// default widths/limits and the response error codes.
package spi_arb_pkg;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_LEN_W       = 6;
   localparam int DEF_TIMEOUT_CYC = 1024;

   // rsp_err values: clean completion versus rejected/aborted transfer
   localparam logic ERR_NONE  = 1'b0;
   localparam logic ERR_ABORT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/spi_request_arbiter_if.sv
// Requester and SPI-controller handshake bundle for spi_request_arbiter.
// slave: the arbiter's view; master: the requesters/controller side.
interface spi_request_arbiter_if
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LEN_W   = DEF_LEN_W
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ*LEN_W-1:0]  req_len;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;
   logic                      spi_start;
   logic [DATA_W-1:0]         spi_wdata;
   logic [LEN_W-1:0]          spi_len;
   logic                      spi_done;
   logic [DATA_W-1:0]         spi_rdata;

   modport slave (
      input  req_valid, req_wdata, req_len, spi_done, spi_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             spi_start, spi_wdata, spi_len
   );

   modport master (
      output req_valid, req_wdata, req_len, spi_done, spi_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             spi_start, spi_wdata, spi_len
   );

endinterface

// File: rtl/spi_request_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches from last+1 (mod NUM_REQ)
// upwards and returns the first set request as one-hot grant and index.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       gnt_any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   int pos;

   // Rotating priority scan; the last granted requester is visited last
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      pos     = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         pos = (int'(last) + off) % NUM_REQ;
         if (!gnt_any && req[pos]) begin
            gnt_any  = 1'b1;
            gnt[pos] = 1'b1;
            gnt_idx  = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter sharing one SPI controller among NUM_REQ requesters.
// IDLE picks and latches a winner, ISSUE hands the command over, WAIT holds
// it until the controller completes, RESP returns the result to the owner.
// Optional build macro SPI_ARB_TIMEOUT_EN adds a WAIT watchdog that aborts
// the transfer with rsp_err=1 after TIMEOUT_CYC cycles without spi_done.
module spi_request_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                       axi_clk,
   input  logic                       axi_resetn,
   spi_request_arbiter_if.slave       bus,
   output logic [$clog2(NUM_REQ)-1:0] cur_owner
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               len_bad;
   logic [NUM_REQ-1:0] ready;
   logic [NUM_REQ-1:0] rsp_vld;
   logic               start;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req     (bus.req_valid),
      .last    (owner_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // A length of zero or wider than the frame cannot be sent
   assign len_bad = (len_q == '0) || (int'(len_q) > DATA_W);

   // Next-state and handshake decode; every output defaults to idle
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wdata_d = wdata_q;
      len_d   = len_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      ready   = '0;
      rsp_vld = '0;
      start   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               owner_d = gnt_idx;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (gnt[i]) begin
                     wdata_d = bus.req_wdata[i*DATA_W +: DATA_W];
                     len_d   = bus.req_len[i*LEN_W +: LEN_W];
                  end
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A requester that withdrew before acceptance simply loses its slot
            if (!bus.req_valid[owner_q]) begin
               state_d = ST_IDLE;
            end else begin
               ready[owner_q] = 1'b1;
               if (len_bad) begin
                  rdata_d = '0;
                  err_d   = ERR_ABORT;
                  state_d = ST_RESP;
               end else begin
                  start   = 1'b1;
                  err_d   = ERR_NONE;
                  state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         ST_WAIT: begin
            if (bus.spi_done) begin
               rdata_d = bus.spi_rdata;
               err_d   = ERR_NONE;
               state_d = ST_RESP;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               rdata_d = '0;
               err_d   = ERR_ABORT;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         ST_RESP: begin
            rsp_vld[owner_q] = 1'b1;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and latched transaction registers; reset gives requester 0 priority
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q <= ST_IDLE;
         owner_q <= IDX_W'(NUM_REQ - 1);
         wdata_q <= '0;
         len_q   <= '0;
         rdata_q <= '0;
         err_q   <= ERR_NONE;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wdata_q <= wdata_d;
         len_q   <= len_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.spi_start = start;
   assign bus.spi_wdata = wdata_q;
   assign bus.spi_len   = len_q;
   assign cur_owner     = owner_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter. Define SPI_ARB_TIMEOUT_EN to
// exercise the watchdog build; otherwise the never-completing WAIT is checked.
module tb_spi_request_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int DATA_W      = 32;
   localparam int LEN_W       = 6;
   localparam int TIMEOUT_CYC = 16;

   logic       axi_clk    = 1'b0;
   logic       axi_resetn = 1'b0;
   logic [1:0] cur_owner;

   spi_request_arbiter_if #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W)
   ) bus ();

   spi_request_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .DATA_W      (DATA_W),
      .LEN_W       (LEN_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .axi_clk    (axi_clk),
      .axi_resetn (axi_resetn),
      .bus        (bus),
      .cur_owner  (cur_owner)
   );

   always #5 axi_clk = ~axi_clk;

   int n_checks  = 0;
   int n_fail    = 0;
   int start_cnt = 0;
   int rsp_cnt   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // One clock: return 2 time units after the rising edge
   task automatic step();
      @(posedge axi_clk);
      #2;
   endtask

   task automatic set_req(input int i, input logic [DATA_W-1:0] w, input int len);
      bus.req_wdata[i*DATA_W +: DATA_W] = w;
      bus.req_len[i*LEN_W +: LEN_W]     = LEN_W'(len);
   endtask

   // Continuous monitor on the falling edge
   always @(negedge axi_clk) begin
      check("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
      check("rsp_onehot0", 64'($onehot0(bus.rsp_valid)), 64'd1);
      if (bus.spi_start) start_cnt++;
      if (|bus.rsp_valid) rsp_cnt++;
   end

   initial begin
      int s0, r0, lat, k;
      int grants[$];
      bit seen;

      bus.req_valid = '0;
      bus.req_wdata = '0;
      bus.req_len   = '0;
      bus.spi_done  = 1'b0;
      bus.spi_rdata = '0;

      // Reset state
      repeat (3) step();
      check("rst_ctrl", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.spi_start}, 0);
      check("rst_rdata", bus.rsp_rdata, 0);
      check("rst_wdata", bus.spi_wdata, 0);
      check("rst_len", bus.spi_len, 0);
      check("rst_owner", cur_owner, 3);
      axi_resetn = 1'b1;
      step();

      // Single request on requester 2
      s0 = start_cnt;
      r0 = rsp_cnt;
      set_req(2, 32'hA5A5_0001, 32);
      bus.req_valid = 4'b0100;
      lat = 1;
      step(); lat++;
      check("s_ready", bus.req_ready, 4'b0100);
      check("s_start", bus.spi_start, 1);
      check("s_wdata", bus.spi_wdata, 32'hA5A5_0001);
      check("s_len", bus.spi_len, 32);
      check("s_owner", cur_owner, 2);
      step(); lat++;
      check("s_start_off", bus.spi_start, 0);
      check("s_wdata_hold", bus.spi_wdata, 32'hA5A5_0001);
      check("s_rsp_early", bus.rsp_valid, 0);
      bus.req_valid = '0;
      bus.spi_done  = 1'b1;
      bus.spi_rdata = 32'h1234_5678;
      step(); lat++;
      check("s_rsp_valid", bus.rsp_valid, 4'b0100);
      check("s_latency", lat, 4);
      check("s_rdata", bus.rsp_rdata, 32'h1234_5678);
      check("s_err", bus.rsp_err, 0);
      bus.spi_done  = 1'b0;
      bus.spi_rdata = '0;
      step();
      check("s_rsp_pulse", bus.rsp_valid, 0);
      check("s_start_cnt", start_cnt - s0, 1);
      check("s_rsp_cnt", rsp_cnt - r0, 1);

      // Reset pulsed during WAIT
      set_req(3, 32'hDEAD_BEEF, 8);
      bus.req_valid = 4'b1000;
      step();
      check("r_ready", bus.req_ready, 4'b1000);
      step();
      bus.req_valid = '0;
      check("r_wait_wdata", bus.spi_wdata, 32'hDEAD_BEEF);
      r0 = rsp_cnt;
      axi_resetn = 1'b0;
      #1;
      check("r_ctrl_zero", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.spi_start}, 0);
      check("r_wdata_zero", bus.spi_wdata, 0);
      check("r_len_zero", bus.spi_len, 0);
      check("r_rdata_zero", bus.rsp_rdata, 0);
      check("r_owner", cur_owner, 3);
      step();
      step();
      axi_resetn = 1'b1;
      step();
      check("r_no_rsp", rsp_cnt - r0, 0);

      // Contention: all four requesting, completion held high
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h1000_0000 * (i + 1), 8);
      bus.req_valid = 4'b1111;
      bus.spi_done  = 1'b1;
      bus.spi_rdata = 32'h0BAD_F00D;
      for (int c = 0; c < 100 && grants.size() < 5; c++) begin
         step();
         if (bus.req_ready != '0) grants.push_back($clog2(bus.req_ready));
      end
      check("c_grant_count", grants.size(), 5);
      for (int g = 0; g < grants.size() && g < 5; g++)
         check($sformatf("c_grant%0d", g), grants[g], g % NUM_REQ);
      step();
      step();
      check("c_rsp_valid", bus.rsp_valid, 4'b0001);
      check("c_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
      bus.req_valid = '0;
      step();

      // Spurious completion in IDLE
      r0 = rsp_cnt;
      s0 = start_cnt;
      for (int c = 0; c < 3; c++) begin
         step();
         check("sp_rsp", bus.rsp_valid, 0);
         check("sp_owner", cur_owner, 0);
         check("sp_wdata", bus.spi_wdata, 32'h1000_0000);
      end
      check("sp_rsp_cnt", rsp_cnt - r0, 0);
      check("sp_start_cnt", start_cnt - s0, 0);
      bus.spi_done  = 1'b0;
      bus.spi_rdata = '0;

      // Illegal lengths: 0 then 40
      s0 = start_cnt;
      for (int b = 0; b < 2; b++) begin
         set_req(1, 32'hFFFF_FFFF, (b == 0) ? 0 : 40);
         bus.req_valid = 4'b0010;
         step();
         check($sformatf("bl%0d_ready", b), bus.req_ready, 4'b0010);
         check($sformatf("bl%0d_start", b), bus.spi_start, 0);
         step();
         check($sformatf("bl%0d_rsp", b), bus.rsp_valid, 4'b0010);
         check($sformatf("bl%0d_err", b), bus.rsp_err, 1);
         check($sformatf("bl%0d_rdata", b), bus.rsp_rdata, 0);
         bus.req_valid = '0;
         step();
      end
      check("bl_start_cnt", start_cnt - s0, 0);

      // Controller never completes
      set_req(0, 32'h0000_00FF, 16);
      bus.req_valid = 4'b0001;
      step();
      check("t_start", bus.spi_start, 1);
      step();
      bus.req_valid = '0;
      check("t_err_clear", bus.rsp_err, 0);
      r0 = rsp_cnt;
`ifdef SPI_ARB_TIMEOUT_EN
      k    = 0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         step();
         k++;
         seen = (bus.rsp_valid != '0);
      end
      check("t_cycles", k, TIMEOUT_CYC);
      check("t_rsp", bus.rsp_valid, 4'b0001);
      check("t_err", bus.rsp_err, 1);
      check("t_rdata", bus.rsp_rdata, 0);
      step();
`else
      repeat (1000) step();
      check("t_no_rsp", rsp_cnt - r0, 0);
      bus.spi_done  = 1'b1;
      bus.spi_rdata = 32'hCAFE_0001;
      step();
      check("t_late_rsp", bus.rsp_valid, 4'b0001);
      check("t_late_err", bus.rsp_err, 0);
      check("t_late_rdata", bus.rsp_rdata, 32'hCAFE_0001);
      bus.spi_done = 1'b0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
